// File: rtl/dff_pkg.sv
// Legal parameter ranges for the dff pipeline and a helper used by its
// elaboration-time parameter check.
package dff_pkg;

   localparam int BW_MIN     = 1;
   localparam int BW_MAX     = 64;
   localparam int NSTAGE_MIN = 1;
   localparam int NSTAGE_MAX = 8;

   function automatic bit in_range(input int val, input int lo, input int hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/dff_stage.sv
// One BW-wide register stage with asynchronous active-low reset to RST_VAL.
module dff_stage #(
   parameter int            BW      = 1,
   parameter logic [BW-1:0] RST_VAL = '0
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic [BW-1:0] i_d,
   output logic [BW-1:0] o_q
);

   logic [BW-1:0] q_q;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= i_d;
      end
   end

   assign o_q = q_q;

endmodule

// File: rtl/dff.sv
// NSTAGE-deep register pipeline: i_d -> stage0 -> ... -> o_q, with every
// stage cleared asynchronously to RST_VAL (truncated to BW bits).
module dff
   import dff_pkg::*;
#(
   parameter int          BW      = 1,
   parameter logic [63:0] RST_VAL = 64'd0,
   parameter int          NSTAGE  = 1
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic [BW-1:0] i_d,
   output logic [BW-1:0] o_q
);

   if (!in_range(BW, BW_MIN, BW_MAX) || !in_range(NSTAGE, NSTAGE_MIN, NSTAGE_MAX)) begin : g_bad_param
      $fatal(1, "dff: BW must be 1..64 and NSTAGE 1..8");
   end

   localparam logic [BW-1:0] RST_TRUNC = RST_VAL[BW-1:0];

   // chain[k] feeds stage k; chain[NSTAGE] is the last stage's register
   logic [BW-1:0] chain [NSTAGE+1];

   assign chain[0] = i_d;

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      dff_stage #(
         .BW      (BW),
         .RST_VAL (RST_TRUNC)
      ) u_stage (
         .i_clk  (i_clk),
         .i_rstn (i_rstn),
         .i_d    (chain[k]),
         .o_q    (chain[k+1])
      );
   end

   assign o_q = chain[NSTAGE];

endmodule

// File: tb/tb_dff.sv
// Directed bench for dff: a default single-bit instance and an
// 8-bit, 3-stage instance resetting to 8'hA5.
`timescale 1ns/1ps
module tb_dff;

   logic       clk;
   logic       rstn_a;
   logic [0:0] d_a;
   logic [0:0] q_a;
   logic       rstn_b;
   logic [7:0] d_b;
   logic [7:0] q_b;

   int errors = 0;
   int checks = 0;

   dff u_dut_a (
      .i_clk  (clk),
      .i_rstn (rstn_a),
      .i_d    (d_a),
      .o_q    (q_a)
   );

   dff #(
      .BW      (8),
      .RST_VAL (64'hA5),
      .NSTAGE  (3)
   ) u_dut_b (
      .i_clk  (clk),
      .i_rstn (rstn_b),
      .i_d    (d_b),
      .o_q    (q_b)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   typedef struct {
      logic d;
      int   off;
      logic exp;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic after_edge();
      @(posedge clk);
      #0.001;
   endtask

   initial begin
      #90000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      real dly;

      vecs[0]  = '{1'b1,  0, 1'b1};
      vecs[1]  = '{1'b0, 50, 1'b0};
      vecs[2]  = '{1'b1, 99, 1'b1};
      vecs[3]  = '{1'b1, 25, 1'b1};
      vecs[4]  = '{1'b0, 10, 1'b0};
      vecs[5]  = '{1'b0, 75, 1'b0};
      vecs[6]  = '{1'b1,  5, 1'b1};
      vecs[7]  = '{1'b0, 90, 1'b0};
      vecs[8]  = '{1'b1, 50, 1'b1};
      vecs[9]  = '{1'b0,  0, 1'b0};
      vecs[10] = '{1'b1, 60, 1'b1};
      vecs[11] = '{1'b1, 30, 1'b1};

      rstn_a = 1'b0;
      rstn_b = 1'b0;
      d_a    = 1'b0;
      d_b    = 8'h00;
      #1;
      chk("reset_a", 64'(q_a), 64'h0);
      chk("reset_b", 64'(q_b), 64'hA5);
      #1 rstn_a = 1'b1;

      // Table: each offset is percent of the period after the previous edge
      after_edge();
      for (int i = 0; i < 12; i++) begin
         dly = (vecs[i].off == 0) ? 0.0 : (real'(vecs[i].off) * 0.1 - 0.001);
         #(dly);
         d_a = vecs[i].d;
         #0.001;
         if (i > 0) chk($sformatf("hold_%0d", i), 64'(q_a), 64'(vecs[i-1].exp));
         @(posedge clk);
         #0.001;
         chk($sformatf("vec_%0d", i), 64'(q_a), 64'(vecs[i].exp));
      end

      // Change landing on an edge is taken one edge later
      after_edge();
      d_a = 1'b0;
      #0.001;
      chk("edge_coincident_hold", 64'(q_a), 64'h1);
      after_edge();
      chk("edge_coincident_next", 64'(q_a), 64'h0);

      // Asynchronous reset mid-cycle
      d_a = 1'b1;
      after_edge();
      chk("pre_reset_one", 64'(q_a), 64'h1);
      #3 rstn_a = 1'b0;
      #0.5;
      chk("async_reset_now", 64'(q_a), 64'h0);
      for (int c = 0; c < 3; c++) begin
         after_edge();
         chk($sformatf("reset_hold_%0d", c), 64'(q_a), 64'h0);
      end
      #4 rstn_a = 1'b1;
      #1;
      chk("release_no_edge", 64'(q_a), 64'h0);
      after_edge();
      chk("release_first_edge", 64'(q_a), 64'h1);

      // Glitch wholly between edges
      d_a = 1'b0;
      after_edge();
      chk("glitch_pre", 64'(q_a), 64'h0);
      #2 d_a = 1'b1;
      #3 d_a = 1'b0;
      #1;
      chk("glitch_mid", 64'(q_a), 64'h0);
      after_edge();
      chk("glitch_post", 64'(q_a), 64'h0);

      // Parameterised instance: 3-stage latency and reset value
      rstn_b = 1'b1;
      d_b    = 8'h3C;
      after_edge();
      chk("b_e1", 64'(q_b), 64'hA5);
      d_b = 8'h5A;
      after_edge();
      chk("b_e2", 64'(q_b), 64'hA5);
      d_b = 8'h77;
      after_edge();
      chk("b_e3", 64'(q_b), 64'h3C);
      after_edge();
      chk("b_e4", 64'(q_b), 64'h5A);
      after_edge();
      chk("b_e5", 64'(q_b), 64'h77);

      // Reset with data in flight flushes every stage
      #3 rstn_b = 1'b0;
      #0.5;
      chk("b_async_reset", 64'(q_b), 64'hA5);
      d_b = 8'h12;
      after_edge();
      chk("b_reset_hold", 64'(q_b), 64'hA5);
      #2 rstn_b = 1'b1;
      after_edge();
      chk("b_flush_f1", 64'(q_b), 64'hA5);
      after_edge();
      chk("b_flush_f2", 64'(q_b), 64'hA5);
      after_edge();
      chk("b_flush_f3", 64'(q_b), 64'h12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dff.md
DFF -- requirements
Module: dff

Interface
REQ-001 Parameter BW, default 1: data width of i_d/o_q in bits; legal range 1..64.
REQ-002 Parameter RST_VAL, default 0: value loaded into every stage on reset; truncated to BW bits.
REQ-003 Parameter NSTAGE, default 1: number of cascaded register stages from i_d to o_q; legal range 1..8.
REQ-004 i_clk  input  1  clock; all state updates on its rising edge only.
REQ-005 i_rstn  input  1  asynchronous, active-low reset.
REQ-006 i_d  input  BW  data input, sampled on each rising i_clk edge.
REQ-007 o_q  output  BW  registered data output, driven directly from the last register stage.

Function
REQ-008 With default parameters, o_q SHALL take the value of i_d present immediately before each rising i_clk edge and hold it until the next rising edge.
REQ-009 Latency from i_d to o_q SHALL be exactly NSTAGE rising edges.
REQ-010 Stage k (k>=1) SHALL capture stage k-1 on each rising edge; stage 0 captures i_d.
REQ-011 All stages SHALL update simultaneously: non-blocking semantics, no shoot-through between stages in one edge.
REQ-012 An i_d change coincident with a rising edge SHALL NOT be captured on that edge; it is captured on the following edge.
REQ-013 An i_d change between edges SHALL have no effect on o_q until the next rising edge; o_q is glitch-free between edges.
REQ-014 o_q SHALL have no combinational path from i_d.
REQ-015 Falling i_clk edges SHALL have no effect.
REQ-016 There is no enable; every rising edge while i_rstn=1 loads a new value.
REQ-017 Without any reset assertion, stage contents before the first rising edge are unspecified (X in simulation); after NSTAGE edges o_q is fully defined.
REQ-018 Each bit of the BW-wide path SHALL be independent; no arithmetic or bit reordering.

Reset
REQ-019 i_rstn=0 SHALL force every stage, and therefore o_q, to RST_VAL immediately, without waiting for a clock edge.
REQ-020 While i_rstn=0, rising edges SHALL be ignored and o_q SHALL hold RST_VAL.
REQ-021 On i_rstn going 0->1, the first rising edge at or after release SHALL capture i_d normally.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight pipeline data.
REQ-023 Reset SHALL be applied directly to the registers; the block provides no reset synchronizer, and the integrator guarantees release timing.
REQ-024 Tying i_rstn to 1 is a legal use; REQ-017 then applies.

Structure
REQ-025 No shared package is required; BW, RST_VAL and NSTAGE are module parameters only.
REQ-026 One sub-module, dff_stage, SHALL implement a single BW-wide stage with asynchronous active-low reset to RST_VAL.
REQ-027 dff SHALL instantiate NSTAGE dff_stage instances in a generate loop, chained i_d -> stage0 -> ... -> o_q.
REQ-028 An elaboration-time check SHALL reject out-of-range BW or NSTAGE.

Verification
REQ-029 Bench clock: 100 MHz (10 ns period), i_clk starting at 1.
REQ-030 Scenario, random data: i_rstn=1; 100 cycles of random i_d, each change at a random 0-100 % offset within the cycle -> o_q at every rising edge equals i_d sampled just before that edge; for offsets 0 % and 100 % the edge-coincident value is captured on the next edge.
REQ-031 Scenario, async reset: o_q=1, drive i_rstn=0 mid-cycle -> o_q=0 at once with no clock edge; hold reset 3 cycles with i_d=1 -> o_q stays 0.
REQ-032 Scenario, reset release: release i_rstn with i_d=1 -> o_q=1 after the first rising edge following release.
REQ-033 Scenario, mid-cycle glitch: pulse i_d 0->1->0 wholly between two edges -> o_q stays 0.
REQ-034 Scenario, parameterised: BW=8, NSTAGE=3, RST_VAL=8'hA5; reset, then i_d=8'h3C for one cycle -> o_q=8'hA5 until the 3rd edge after sampling, 8'h3C for one cycle, then follows later i_d.
